// File: rtl/telemetry_uart_tx.sv
// telemetry_uart_tx: buffers 8-bit converter samples in a small FIFO and sends them as UART frames
// Ports: clk/rst (sync, active-high), sample_in/sample_valid/sample_ready (write handshake),
//        tx (registered serial line, idle high), busy (frame or data pending), overflow (sticky drop flag)
// Define TELEMETRY_TX_PARITY_EN to append an even-parity bit (11-bit frames); default is 10-bit frames.
module telemetry_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t        state_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [TW-1:0] tmr_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q, head;
  logic          tx_q, tx_d, ovf_q, wr, pop, tmr_last;
`ifdef TELEMETRY_TX_PARITY_EN
  logic          par_q;
`endif
  assign head         = mem_q[rd_ptr_q];
  assign sample_ready = count_q != CW'(FIFO_DEPTH);
  assign wr           = sample_valid && sample_ready;
  assign tmr_last     = tmr_q == TW'(CLKS_PER_BIT - 1);
  // A frame ending with data still queued reloads straight into START, so frames stay contiguous.
  assign pop          = count_q != '0 && (state_q == IDLE || (state_q == STOP && tmr_last));
  assign busy         = state_q != IDLE || count_q != '0;
  assign tx           = tx_q;
  assign overflow     = ovf_q;
  always_comb begin
    tx_d = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
`ifdef TELEMETRY_TX_PARITY_EN
    if (state_q == PARITY) tx_d = par_q;
`endif
  end
  always_ff @(posedge clk)
    if (wr) mem_q[wr_ptr_q] <= sample_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(wr) - CW'(pop);
      if (sample_valid && !sample_ready) ovf_q <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef TELEMETRY_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      tx_q  <= tx_d;
      tmr_q <= (state_q == IDLE || tmr_last) ? '0 : tmr_q + TW'(1);
      if (pop) begin
        shift_q <= head;
`ifdef TELEMETRY_TX_PARITY_EN
        par_q   <= ^head;
`endif
      end
      case (state_q)
        IDLE: if (pop) state_q <= START;
        START: if (tmr_last) begin
          state_q <= DATA;
          bit_q   <= '0;
        end
        DATA: if (tmr_last) begin
          shift_q <= shift_q >> 1;
          bit_q   <= bit_q + 3'd1;
`ifdef TELEMETRY_TX_PARITY_EN
          if (bit_q == 3'd7) state_q <= PARITY;
`else
          if (bit_q == 3'd7) state_q <= STOP;
`endif
        end
`ifdef TELEMETRY_TX_PARITY_EN
        PARITY: if (tmr_last) state_q <= STOP;
`endif
        STOP: if (tmr_last) state_q <= pop ? START : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
